// File: rtl/jogo_pkg.sv
// -----------------------------------------------------------------------------
// jogo_pkg
// Shared definitions for the battleship attack-stage turn sequencer:
//   - board geometry (5 columns x 7 rows = 35 cells)
//   - sequencer state encoding (estado_t)
//   - cell index helper idx(col, lin) = col*7 + lin, matching the packing of
//     the ship map and of the attack manager hit matrix.
// -----------------------------------------------------------------------------
package jogo_pkg;

  localparam int NUM_COLUNAS = 5;
  localparam int NUM_LINHAS  = 7;
  localparam int NUM_CELULAS = 35;

  // Saturation point of the hit counter: every cell of the board is a ship cell.
  localparam logic [5:0] MAX_ACERTOS = 6'd35;

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    ATAQUE   = 3'd1,
    VALIDA   = 3'd2,
    DISPARA  = 3'd3,
    ESPERA   = 3'd4,
    VERIFICA = 3'd5,
    FIM      = 3'd6
  } estado_t;

  // Flat cell index; only meaningful for col 0-4 and lin 0-6.
  function automatic logic [5:0] idx(input logic [2:0] col, input logic [2:0] lin);
    return ({3'b000, col} * 6'd7) + {3'b000, lin};
  endfunction

endpackage

// File: rtl/controlador_de_jogo_if.sv
// -----------------------------------------------------------------------------
// controlador_de_jogo_if
// Board I/O and attack-manager signals seen by the turn sequencer.
//   master : the sequencer (controlador_de_jogo)
//   slave  : the environment (buttons, switches, ship map, attack manager)
// Signals:
//   botao_iniciar, botao_confirmar : raw button levels, asynchronous
//   coordColuna[2:0], coordLinha[2:0] : target coordinate
//   mapa[34:0], matriz[34:0] : ship map / hit matrix, bit = col*7+linha
//   enable_ataque, confirmar_ataque : attack manager control
//   tentativas[4:0], acertos[5:0] : shot and hit counters
//   acerto, repetido, erro_coord : single-cycle shot result pulses
//   jogo_ativo, vitoria, derrota : game status levels
// -----------------------------------------------------------------------------
interface controlador_de_jogo_if;
  import jogo_pkg::*;

  logic                   botao_iniciar;
  logic                   botao_confirmar;
  logic [2:0]             coordColuna;
  logic [2:0]             coordLinha;
  logic [NUM_CELULAS-1:0] mapa;
  logic [NUM_CELULAS-1:0] matriz;
  logic                   enable_ataque;
  logic                   confirmar_ataque;
  logic [4:0]             tentativas;
  logic [5:0]             acertos;
  logic                   acerto;
  logic                   repetido;
  logic                   erro_coord;
  logic                   jogo_ativo;
  logic                   vitoria;
  logic                   derrota;

  modport master (
    input  botao_iniciar, botao_confirmar, coordColuna, coordLinha, mapa, matriz,
    output enable_ataque, confirmar_ataque, tentativas, acertos,
           acerto, repetido, erro_coord, jogo_ativo, vitoria, derrota
  );

  modport slave (
    output botao_iniciar, botao_confirmar, coordColuna, coordLinha, mapa, matriz,
    input  enable_ataque, confirmar_ataque, tentativas, acertos,
           acerto, repetido, erro_coord, jogo_ativo, vitoria, derrota
  );

endinterface

// File: rtl/detector_de_borda.sv
// -----------------------------------------------------------------------------
// detector_de_borda
// Conditions a raw asynchronous button level into a single-cycle event:
// two-flop synchronizer followed by a registered rising-edge detector.
// The event rises 3 clock edges after the button level rises.
// Ports:
//   i_clk    : system clock
//   i_rst    : asynchronous active-high reset
//   i_botao  : raw button level
//   o_evento : one-cycle pulse per press
// -----------------------------------------------------------------------------
module detector_de_borda (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_botao,
  output logic o_evento
);

  logic r_sync1;
  logic r_sync2;
  logic r_anterior;
  logic r_evento;

  // Synchronizer chain, previous-level flop and registered rising-edge pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_anterior <= 1'b0;
      r_evento   <= 1'b0;
    end else begin
      r_sync1    <= i_botao;
      r_sync2    <= r_sync1;
      r_anterior <= r_sync2;
      r_evento   <= r_sync2 & ~r_anterior;
    end
  end

  assign o_evento = r_evento;

endmodule

// File: rtl/controlador_de_jogo.sv
// -----------------------------------------------------------------------------
// controlador_de_jogo
// Turn sequencer for the battleship attack stage. Owns the attack manager's
// enable/confirm lines, validates each shot, tracks shot history, attempts
// and hits, and declares victory or defeat.
// Ports:
//   clock   : system clock, rising edge
//   reset   : asynchronous active-high reset
//   io_jogo : controlador_de_jogo_if.master (buttons, coordinates, map,
//             hit matrix, attack manager control and status outputs)
// Parameter:
//   MAX_TENTATIVAS : shots allowed before defeat (1-31)
// Build option:
//   CONTROLADOR_IGNORA_REPETIDO_EN defined -> a repeated cell is rejected
//   without consuming an attempt; undefined -> it is fired normally but never
//   counts as a hit.
// -----------------------------------------------------------------------------
module controlador_de_jogo #(
  parameter int MAX_TENTATIVAS = 20
) (
  input  logic                          clock,
  input  logic                          reset,
  controlador_de_jogo_if.master         io_jogo
);
  import jogo_pkg::*;

  localparam logic [4:0] LIMITE_TENTATIVAS = 5'(MAX_TENTATIVAS);

  estado_t r_estado;
  estado_t w_prox;

  logic w_ev_iniciar;
  logic w_ev_confirmar;

  // Shot datapath
  logic [2:0]             r_col;
  logic [2:0]             r_lin;
  logic                   r_tiro_repetido;
  logic [NUM_CELULAS-1:0] r_historico;
  logic [4:0]             r_tentativas;
  logic [5:0]             r_acertos;
  logic                   r_pendente;

  // Registered outputs
  logic r_enable;
  logic r_confirmar;
  logic r_acerto;
  logic r_repetido;
  logic r_erro;
  logic r_jogo_ativo;
  logic r_vitoria;
  logic r_derrota;

  // Next values of the registered outputs
  logic w_enable_nxt;
  logic w_confirmar_nxt;
  logic w_acerto_nxt;
  logic w_repetido_nxt;
  logic w_erro_nxt;
  logic w_jogo_ativo_nxt;
  logic w_vitoria_nxt;
  logic w_derrota_nxt;

  logic       w_coord_valida;
  logic [5:0] w_idx_entrada;
  logic [5:0] w_idx_tiro;
  logic       w_ja_disparado;
  logic       w_mapa_vazio;
  logic       w_mapa_completo;
  logic       w_tiro_acerta;
  logic       w_abortar;

  detector_de_borda u_borda_iniciar (
    .i_clk    (clock),
    .i_rst    (reset),
    .i_botao  (io_jogo.botao_iniciar),
    .o_evento (w_ev_iniciar)
  );

  detector_de_borda u_borda_confirmar (
    .i_clk    (clock),
    .i_rst    (reset),
    .i_botao  (io_jogo.botao_confirmar),
    .o_evento (w_ev_confirmar)
  );

  assign w_coord_valida  = (io_jogo.coordColuna < 3'(NUM_COLUNAS)) &&
                           (io_jogo.coordLinha  < 3'(NUM_LINHAS));
  assign w_idx_entrada   = idx(io_jogo.coordColuna, io_jogo.coordLinha);
  assign w_ja_disparado  = w_coord_valida && r_historico[w_idx_entrada];
  assign w_idx_tiro      = idx(r_col, r_lin);
  assign w_mapa_vazio    = (io_jogo.mapa == {NUM_CELULAS{1'b0}});
  assign w_mapa_completo = (io_jogo.matriz == io_jogo.mapa);
  // A repeated cell never scores, even when it is a ship cell.
  assign w_tiro_acerta   = io_jogo.mapa[w_idx_tiro] & ~r_tiro_repetido;
  // Abort requests raised while the shot was in flight are served here.
  assign w_abortar       = w_ev_iniciar | r_pendente;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado <= OCIOSO;
    end else begin
      r_estado <= w_prox;
    end
  end

  // Next-state logic; iniciar always takes priority over confirmar.
  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      OCIOSO: begin
        if (w_ev_iniciar) begin
          w_prox = w_mapa_vazio ? FIM : ATAQUE;
        end else begin
          w_prox = OCIOSO;
        end
      end
      ATAQUE: begin
        if (w_ev_iniciar) begin
          w_prox = OCIOSO;
        end else if (w_ev_confirmar) begin
          w_prox = VALIDA;
        end else begin
          w_prox = ATAQUE;
        end
      end
      VALIDA: begin
        if (w_ev_iniciar) begin
          w_prox = OCIOSO;
        end else if (!w_coord_valida) begin
          w_prox = ATAQUE;
`ifdef CONTROLADOR_IGNORA_REPETIDO_EN
        end else if (w_ja_disparado) begin
          w_prox = ATAQUE;
`endif
        end else begin
          w_prox = DISPARA;
        end
      end
      DISPARA: w_prox = ESPERA;
      ESPERA:  w_prox = VERIFICA;
      VERIFICA: begin
        if (w_abortar) begin
          w_prox = OCIOSO;
        end else if (w_mapa_completo) begin
          w_prox = FIM;
        end else if (r_tentativas == LIMITE_TENTATIVAS) begin
          w_prox = FIM;
        end else begin
          w_prox = ATAQUE;
        end
      end
      FIM: begin
        if (w_ev_iniciar) begin
          w_prox = OCIOSO;
        end else begin
          w_prox = FIM;
        end
      end
      default: w_prox = OCIOSO;
    endcase
  end

  // Output decode: next values of all registered outputs.
  always_comb begin
    w_enable_nxt     = (w_prox != OCIOSO);
    w_jogo_ativo_nxt = (w_prox != OCIOSO) && (w_prox != FIM);
    w_confirmar_nxt  = (w_prox == DISPARA);
    w_erro_nxt       = 1'b0;
    w_repetido_nxt   = 1'b0;
    w_acerto_nxt     = 1'b0;
    w_vitoria_nxt    = 1'b0;
    w_derrota_nxt    = 1'b0;
    case (r_estado)
      OCIOSO: begin
        // Starting with an empty map is an immediate win.
        w_vitoria_nxt = (w_prox == FIM);
      end
      VALIDA: begin
        if (!w_ev_iniciar) begin
          w_erro_nxt     = ~w_coord_valida;
          w_repetido_nxt = w_ja_disparado;
        end else begin
          w_erro_nxt     = 1'b0;
          w_repetido_nxt = 1'b0;
        end
      end
      VERIFICA: begin
        if (w_prox != OCIOSO) begin
          w_acerto_nxt  = w_tiro_acerta;
          w_vitoria_nxt = (w_prox == FIM) && w_mapa_completo;
          w_derrota_nxt = (w_prox == FIM) && !w_mapa_completo;
        end else begin
          w_acerto_nxt  = 1'b0;
          w_vitoria_nxt = 1'b0;
          w_derrota_nxt = 1'b0;
        end
      end
      FIM: begin
        if (w_prox == FIM) begin
          w_vitoria_nxt = r_vitoria;
          w_derrota_nxt = r_derrota;
        end else begin
          w_vitoria_nxt = 1'b0;
          w_derrota_nxt = 1'b0;
        end
      end
      default: begin
        w_erro_nxt = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_enable     <= 1'b0;
      r_confirmar  <= 1'b0;
      r_acerto     <= 1'b0;
      r_repetido   <= 1'b0;
      r_erro       <= 1'b0;
      r_jogo_ativo <= 1'b0;
      r_vitoria    <= 1'b0;
      r_derrota    <= 1'b0;
    end else begin
      r_enable     <= w_enable_nxt;
      r_confirmar  <= w_confirmar_nxt;
      r_acerto     <= w_acerto_nxt;
      r_repetido   <= w_repetido_nxt;
      r_erro       <= w_erro_nxt;
      r_jogo_ativo <= w_jogo_ativo_nxt;
      r_vitoria    <= w_vitoria_nxt;
      r_derrota    <= w_derrota_nxt;
    end
  end

  // Shot datapath: counters, history, held coordinate and pending abort.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_col           <= 3'd0;
      r_lin           <= 3'd0;
      r_tiro_repetido <= 1'b0;
      r_historico     <= {NUM_CELULAS{1'b0}};
      r_tentativas    <= 5'd0;
      r_acertos       <= 6'd0;
      r_pendente      <= 1'b0;
    end else begin
      if ((r_estado == OCIOSO) && w_ev_iniciar) begin
        r_tentativas <= 5'd0;
        r_acertos    <= 6'd0;
        r_historico  <= {NUM_CELULAS{1'b0}};
      end
      if ((r_estado == VALIDA) && (w_prox == DISPARA)) begin
        r_col                      <= io_jogo.coordColuna;
        r_lin                      <= io_jogo.coordLinha;
        r_tiro_repetido            <= w_ja_disparado;
        r_historico[w_idx_entrada] <= 1'b1;
        if (r_tentativas != LIMITE_TENTATIVAS) begin
          r_tentativas <= r_tentativas + 5'd1;
        end
      end
      if ((r_estado == VERIFICA) && (w_prox != OCIOSO) && w_tiro_acerta &&
          (r_acertos != MAX_ACERTOS)) begin
        r_acertos <= r_acertos + 6'd1;
      end
      if (((r_estado == DISPARA) || (r_estado == ESPERA)) && w_ev_iniciar) begin
        r_pendente <= 1'b1;
      end else if ((r_estado == VERIFICA) || (r_estado == OCIOSO)) begin
        r_pendente <= 1'b0;
      end
    end
  end

  assign io_jogo.enable_ataque    = r_enable;
  assign io_jogo.confirmar_ataque = r_confirmar;
  assign io_jogo.tentativas       = r_tentativas;
  assign io_jogo.acertos          = r_acertos;
  assign io_jogo.acerto           = r_acerto;
  assign io_jogo.repetido         = r_repetido;
  assign io_jogo.erro_coord       = r_erro;
  assign io_jogo.jogo_ativo       = r_jogo_ativo;
  assign io_jogo.vitoria          = r_vitoria;
  assign io_jogo.derrota          = r_derrota;

endmodule

// File: doc/controlador_de_jogo.md
# controlador_de_jogo

Turn sequencer for the battleship attack stage. It owns the attack manager's `enable` and `confirmar` lines and conditions the player's raw buttons into single-cycle events. It validates each shot, tracks shot history, attempts and hits, and declares victory or defeat. It sits between the board I/O (switches, buttons) and the attack manager, and reads the attack manager's hit matrix back.

## Interface
- `MAX_TENTATIVAS`, default 20: number of shots allowed before defeat; range 1–31.
- `clock` in 1: system clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `botao_iniciar` in 1: raw start/abort button, level, asynchronous to `clock`.
- `botao_confirmar` in 1: raw fire button, level, asynchronous to `clock`.
- `coordColuna` in 3: target column, valid 0–4.
- `coordLinha` in 3: target row, valid 0–6.
- `mapa` in 35: ship map `{mapa4..mapa0}`; bit index = col*7+linha.
- `matriz` in 35: attack manager hit matrix, same packing.
- `enable_ataque` out 1: drives the attack manager `enable`.
- `confirmar_ataque` out 1: 1-cycle fire pulse to the attack manager `confirmar`.
- `tentativas` out 5: shots consumed.
- `acertos` out 6: distinct ship cells hit.
- `acerto` out 1: 1-cycle pulse, last shot hit a ship cell.
- `repetido` out 1: 1-cycle pulse, the cell was already fired on.
- `erro_coord` out 1: 1-cycle pulse, the coordinate is out of range.
- `jogo_ativo`, `vitoria`, `derrota` out 1 each: game status levels.

## Operation
- Each button passes through a 2-FF synchronizer and a rising-edge detector, giving one event per press.
- States:
  - `OCIOSO`: `enable_ataque`=0 (clears the matrix).
  - `ATAQUE`: wait for a confirm event.
  - `VALIDA`: check the coordinate and the shot history.
  - `DISPARA`: assert `confirmar_ataque`.
  - `ESPERA`: one cycle for the attack manager to update the matrix.
  - `VERIFICA`: evaluate the shot.
  - `FIM`: game over.
- Transitions:
  - `OCIOSO` + iniciar → `ATAQUE`: counters and history cleared. If `mapa`==0, go to `FIM` instead with `vitoria`=1.
  - `ATAQUE` + confirmar → `VALIDA`.
  - `VALIDA`, coordinate out of range → `erro_coord` pulse, back to `ATAQUE`, nothing counted.
  - `VALIDA`, cell already in the history → see Configuration.
  - `VALIDA`, otherwise → `DISPARA`. The history bit is set and `tentativas` increments here.
  - `DISPARA` → `ESPERA` → `VERIFICA`.
  - `VERIFICA`:
    - `acerto` = `mapa[idx]`; on a hit, `acertos` increments.
    - If `matriz`==`mapa`, go to `FIM` with `vitoria`=1.
    - Else if `tentativas`==`MAX_TENTATIVAS`, go to `FIM` with `derrota`=1.
    - Else back to `ATAQUE`. Victory has priority over defeat on the last shot.
  - `FIM` + iniciar → `OCIOSO`.
  - iniciar in `ATAQUE`, `VALIDA` or `VERIFICA` → `OCIOSO` (abort).
  - iniciar in `DISPARA` or `ESPERA` is held pending and acted on in `VERIFICA`.
- Confirm events outside `ATAQUE` are discarded. Simultaneous iniciar and confirmar: iniciar wins.
- `jogo_ativo`=1 in every state except `OCIOSO` and `FIM`. `enable_ataque`=1 in every state except `OCIOSO`, so the final board stays visible in `FIM`.
- Counters saturate and never wrap: `tentativas` at `MAX_TENTATIVAS`, `acertos` at 35.

## Timing
- Reset values: state `OCIOSO`; all outputs 0; counters, history and synchronizers 0. Reset mid-game returns to `OCIOSO` on the next edge with no further pulses.
- Button to event: 3 cycles (2 sync + edge detect).
- Event to `confirmar_ataque` high: 2 cycles (`ATAQUE` → `VALIDA` → `DISPARA`); the pulse is exactly 1 cycle.
- `acerto`, `vitoria` and `derrota` are registered on the `VERIFICA` exit edge, i.e. 3 cycles after `confirmar_ataque` rises.
- A new shot can be accepted 1 cycle after `VERIFICA`.
- Coordinates are sampled in `VALIDA` and held in a register through `VERIFICA`.

## Configuration
- `CONTROLADOR_IGNORA_REPETIDO_EN` defined:
  - A repeated cell gives a `repetido` pulse and a return to `ATAQUE`.
  - No attempt is consumed and no `confirmar_ataque` is issued.
- Undefined:
  - A repeated cell gives a `repetido` pulse, consumes an attempt and goes through `DISPARA`/`VERIFICA` normally.
  - `acerto`=0 and `acertos` is unchanged for a repeated cell, even when it is a ship cell.

## Structure
- Package `jogo_pkg`:
  - `NUM_COLUNAS`=5, `NUM_LINHAS`=7, `NUM_CELULAS`=35.
  - State enum `estado_t`.
  - Index function `idx(col,lin)`.
- Sub-module `detector_de_borda`: 2-FF synchronizer plus rising-edge pulse; instantiated twice.

## Test plan
- mapa=bit0 only; iniciar; fire (0,0) → `confirmar_ataque` 1 cycle; `acerto`=1; `acertos`=1; `vitoria`=1; `tentativas`=1.
- `MAX_TENTATIVAS`=3; fire (1,1), (2,2), (3,3) on empty cells, with a nonzero map → `derrota`=1 after the 3rd shot; `tentativas`=3.
- Fire (5,0), then (0,7) → `erro_coord` pulse each; `tentativas`=0; no `confirmar_ataque`.
- Fire (2,3) twice → second shot gives `repetido`. With the macro, `tentativas`=1; without it, `tentativas`=2.
- Last allowed shot also completes the map → `vitoria`=1 and `derrota`=0.
- Assert `reset` during `ESPERA` → all outputs 0 and state `OCIOSO` on the next edge. Assert iniciar during `ESPERA` → abort taken in `VERIFICA`, `enable_ataque`=0.
